rsnn_lif_layer: RTL

Parametrised layer of leaky integrate-and-fire (LIF) neurons for the RSNN tile. It replaces the fixed-size single-neuron datapath.
- Neurons are time-multiplexed: one neuron is updated per clock against a binary input spike vector.
- Uses a write-port weight memory and a runtime threshold/leak configuration.
- Sits between the ui_in/uio_in input-capture logic and the uo_out spike register in the top-level tt_um wrapper.

---
 rtl/rsnn_pkg.sv | 34 +++
 rtl/rsnn_lif_update.sv | 58 +++++
 rtl/rsnn_lif_layer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/rsnn_pkg.sv
// Shared types, constants and helpers for the time-multiplexed LIF layer.
// The RSNN_RECURRENT_EN macro widens the synapse vector with the layer's own spikes.
package rsnn_pkg;

  localparam int LEAK_W   = 3;
  localparam int REFRAC_W = 3;

`ifdef RSNN_RECURRENT_EN
  localparam bit RECURRENT = 1'b1;
`else
  localparam bit RECURRENT = 1'b0;
`endif

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_UPDATE = 2'd1;
  localparam state_t ST_FINISH = 2'd2;

  function automatic int n_syn(input int n_inputs, input int n_neurons);
    return n_inputs + (RECURRENT ? n_neurons : 0);
  endfunction

  // Clamp to the signed range of the given width; never wraps.
  function automatic logic signed [31:0] saturate(input logic signed [31:0] x, input int width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    if (x > hi) return hi;
    else if (x < lo) return lo;
    else return x;
  endfunction

endpackage

// File: rtl/rsnn_lif_update.sv
// Combinational single-neuron LIF step: masked weight sum, leak, saturation,
// threshold compare and refractory handling. Shared across all neurons.
module rsnn_lif_update
  import rsnn_pkg::*;
#(
  parameter int N_SYN   = 8,
  parameter int W_WIDTH = 4,
  parameter int V_WIDTH = 10,
  parameter int REFRAC  = 2
) (
  input  logic [N_SYN*W_WIDTH-1:0]  weights,
  input  logic [N_SYN-1:0]          syn_in,
  input  logic signed [V_WIDTH-1:0] v,
  input  logic [REFRAC_W-1:0]       refrac,
  input  logic signed [V_WIDTH-1:0] threshold,
  input  logic [LEAK_W-1:0]         leak_shift,
  output logic signed [V_WIDTH-1:0] v_next,
  output logic [REFRAC_W-1:0]       refrac_next,
  output logic                      spike
);

  localparam int SUM_W = V_WIDTH + 2;

  logic signed [SUM_W-1:0]   syn_sum;
  logic signed [SUM_W-1:0]   leak;
  logic signed [SUM_W-1:0]   vn;
  logic signed [V_WIDTH-1:0] v_sat;

  always_comb begin
    syn_sum = '0;
    for (int j = 0; j < N_SYN; j++) begin
      if (syn_in[j]) syn_sum = syn_sum + SUM_W'($signed(weights[j*W_WIDTH +: W_WIDTH]));
    end
  end

  // A zero shift must mean "no leak", not "leak everything".
  always_comb begin
    leak = '0;
    if (leak_shift != '0) leak = SUM_W'(v >>> leak_shift);
    vn    = SUM_W'(v) - leak + syn_sum;
    v_sat = V_WIDTH'(saturate(32'(vn), V_WIDTH));
  end

  always_comb begin
    spike       = 1'b0;
    v_next      = v_sat;
    refrac_next = refrac;
    if (refrac != '0) begin
      refrac_next = refrac - REFRAC_W'(1);
      v_next      = '0;
    end else if (v_sat >= threshold) begin
      spike       = 1'b1;
      v_next      = '0;
      refrac_next = REFRAC_W'(REFRAC);
    end
  end

endmodule

// File: rtl/rsnn_lif_layer.sv
// Layer of LIF neurons updated one per clock by a shared datapath.
// Define RSNN_RECURRENT_EN to feed the previous step's out_spikes back as extra synapses.
module rsnn_lif_layer
  import rsnn_pkg::*;
#(
  parameter int N_NEURONS = 8,
  parameter int N_INPUTS  = 8,
  parameter int W_WIDTH   = 4,
  parameter int V_WIDTH   = 10,
  parameter int REFRAC    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      step,
  input  logic [N_INPUTS-1:0]       in_spikes,
  input  logic signed [V_WIDTH-1:0] threshold,
  input  logic [LEAK_W-1:0]         leak_shift,
  input  logic                      wr_en,
  input  logic [7:0]                wr_addr,
  input  logic [W_WIDTH-1:0]        wr_data,
  output logic [N_NEURONS-1:0]      out_spikes,
  output logic                      busy,
  output logic                      done
);

  localparam int N_SYN = n_syn(N_INPUTS, N_NEURONS);
  localparam int IDX_W = $clog2(N_NEURONS);

  state_t                    state_reg;
  logic [IDX_W-1:0]          idx_reg;
  logic [N_SYN-1:0]          syn_reg;
  logic signed [V_WIDTH-1:0] thr_reg;
  logic [LEAK_W-1:0]         ls_reg;
  logic [N_NEURONS-1:0]      shadow_reg;

  logic [W_WIDTH-1:0]        w_mem [N_NEURONS][N_SYN];
  logic signed [V_WIDTH-1:0] v_mem [N_NEURONS];
  logic [REFRAC_W-1:0]       refrac_mem [N_NEURONS];

  logic [N_SYN*W_WIDTH-1:0]  w_row;
  logic signed [V_WIDTH-1:0] v_next;
  logic [REFRAC_W-1:0]       refrac_next;
  logic                      spike;

  always_comb begin
    w_row = '0;
    for (int j = 0; j < N_SYN; j++) w_row[j*W_WIDTH +: W_WIDTH] = w_mem[idx_reg][j];
  end

  rsnn_lif_update #(
    .N_SYN  (N_SYN),
    .W_WIDTH(W_WIDTH),
    .V_WIDTH(V_WIDTH),
    .REFRAC (REFRAC)
  ) u_update (
    .weights    (w_row),
    .syn_in     (syn_reg),
    .v          (v_mem[idx_reg]),
    .refrac     (refrac_mem[idx_reg]),
    .threshold  (thr_reg),
    .leak_shift (ls_reg),
    .v_next     (v_next),
    .refrac_next(refrac_next),
    .spike      (spike)
  );

  // Out-of-range addresses match no cell, so they fall through silently.
  for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_neuron
    for (genvar gj = 0; gj < N_SYN; gj++) begin : g_syn
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) w_mem[gi][gj] <= '0;
        else if (wr_en && !busy && (int'(wr_addr) == gi*N_SYN + gj)) w_mem[gi][gj] <= wr_data;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_mem[gi]      <= '0;
        refrac_mem[gi] <= '0;
      end else if (state_reg == ST_UPDATE && idx_reg == IDX_W'(gi)) begin
        v_mem[gi]      <= v_next;
        refrac_mem[gi] <= refrac_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      idx_reg    <= '0;
      syn_reg    <= '0;
      thr_reg    <= '0;
      ls_reg     <= '0;
      shadow_reg <= '0;
      out_spikes <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (step) begin
`ifdef RSNN_RECURRENT_EN
            syn_reg <= {out_spikes, in_spikes};
`else
            syn_reg <= in_spikes;
`endif
            thr_reg   <= threshold;
            ls_reg    <= leak_shift;
            idx_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          shadow_reg[idx_reg] <= spike;
          if (idx_reg == IDX_W'(N_NEURONS - 1)) state_reg <= ST_FINISH;
          else idx_reg <= idx_reg + IDX_W'(1);
        end
        ST_FINISH: begin
          out_spikes <= shadow_reg;
          done       <= 1'b1;
          busy       <= 1'b0;
          state_reg  <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
